clock_tree_gen: RTL
===================

Name: clock_tree_gen

Overview:
Parametrised multi-channel clock-tree generator. It replaces the fixed single-channel tick generator and clock component pair in the FPGA toplevel shell. A programmable prescaler drives N derived clock channels, each with its own high/low tick counts. A mode input selects halt, free-run or single-step, so the board can freeze or step the 6502 core, and a status counter tracks channel-0 rising edges.

Parameters:
NR_OF_CHANNELS, 2, number of derived clock channels (1..8)
CNT_BITS, 8, width of each per-channel high/low phase counter
PRESCALE_BITS, 16, width of the prescaler counter
PRESCALE_RELOAD, 0, prescaler reload value; a tick occurs every PRESCALE_RELOAD+1 FPGA clocks
CH_HIGH_TICKS, {N{8'd1}}, packed NR_OF_CHANNELS*CNT_BITS vector; channel i high-phase length in ticks, 0 treated as 1
CH_LOW_TICKS, {N{8'd1}}, packed NR_OF_CHANNELS*CNT_BITS vector; channel i low-phase length in ticks, 0 treated as 1

Ports:
FPGA_GlobalClock  input  1  board clock; all state sampled on its rising edge
FPGA_GlobalReset_n  input  1  asynchronous active-low reset
mode  input  2  00 halt, 01 run, 10 single-step, 11 halt
step  input  1  asynchronous push-button; a rising edge requests one step
ch_enable  input  NR_OF_CHANNELS  per-channel advance enable (level)
ClockBus  output  5*NR_OF_CHANNELS  per channel i, bits [5i+4:5i]: {FPGA_GlobalClock, neg_tick, pos_tick, ~clk, clk}
step_busy  output  1  high while a single step is in progress
edge_count  output  32  number of channel-0 rising edges since reset; wraps from 0xFFFFFFFF to 0

Behaviour:
- Reset (async assert, sync release): prescaler = PRESCALE_RELOAD; every channel in LOW with counter = its low count; clk = 0, ~clk = 1, pos_tick = 0, neg_tick = 0, step_busy = 0, edge_count = 0; step synchroniser cleared.
- Prescaler: counts down each FPGA clock. At 0 it asserts tick for one cycle and reloads. With reload 0, tick is high every cycle.
- advance = tick & (mode==01 | step_busy). Channel i advances when advance & ch_enable[i].
- Channel FSM has states LOW and HIGH:
  - On advance with counter > 1, the counter decrements.
  - On advance with counter == 1 in LOW, the channel goes to HIGH and loads its high count.
  - On advance with counter == 1 in HIGH, the channel goes to LOW and loads its low count.
  - clk is registered and equals (state==HIGH).
- pos_tick is combinational: high in the FPGA cycle where the channel advances with state LOW and counter == 1, i.e. exactly one FPGA cycle before clk rises. neg_tick is the same for the HIGH to LOW transition. Both are single-cycle pulses.
- step is passed through a 2-FF synchroniser plus an edge detector. A rising edge in mode 10 while step_busy = 0 sets step_busy. step_busy clears on the cycle channel 0 falls (HIGH to LOW). The result is exactly one full channel-0 period beginning from LOW; other enabled channels advance during that window.
- Step edges while step_busy = 1, or in modes other than 10, are ignored (not queued).
- Changing mode from 10 to 00 or 11 mid-step clears step_busy immediately. Channels freeze at their current level and counter, and nothing is reset.
- Changing mode from 10 to 01 clears step_busy; free-run then continues.
- ch_enable[i] low freezes channel i: its level holds and no ticks are emitted.
- If ch_enable[0] is low during a step, step_busy stays high until channel 0 is re-enabled and falls, or until mode leaves 10.
- edge_count increments on each channel-0 LOW to HIGH transition.
- The FPGA_GlobalClock bit in ClockBus is a direct passthrough.

Test Plan:
- Reset while running with PRESCALE_RELOAD = 0 and high/low counts 1/1 -> clk = 0, ~clk = 1, both ticks 0, edge_count = 0, all immediately on FPGA_GlobalReset_n falling.
- Mode 01, ch0 high/low 1/1, ch1 high/low 3/2, reload 0 -> ch0 period 2 clocks; ch1 low for 2 clocks then high for 3; pos_tick in the cycle before each rise; edge_count = 10 after 20 clocks.
- Mode 01, reload 3, ch0 1/1 -> one tick every 4 clocks; clk toggles every 4 clocks; pos_tick width is exactly 1 cycle.
- Mode 10, one step pulse, ch0 2/2, reload 0 -> step_busy high for 4 clocks of advance; edge_count +1; clk ends at 0. A second pulse during busy gives no extra period.
- Mode 10 switched to 00 in the middle of a step while clk = 1 -> step_busy = 0 next cycle; clk stays at 1 with no further ticks; mode 01 then resumes from the frozen counter.
- ch_enable = 2'b10 in mode 01 -> ch0 frozen at its level with no ticks; ch1 toggles normally; edge_count constant.

Source files
------------

// File: rtl/clock_tree_gen_if.sv
// Control and clock-bus bundle of clock_tree_gen: mode/step/enable in, ClockBus and status out.
interface clock_tree_gen_if #(
    parameter int NR_OF_CHANNELS = 2
);
    logic [1:0]                    mode;
    logic                          step;
    logic [NR_OF_CHANNELS-1:0]     ch_enable;
    logic [5*NR_OF_CHANNELS-1:0]   ClockBus;
    logic                          step_busy;
    logic [31:0]                   edge_count;

    modport master (
        output mode, step, ch_enable,
        input  ClockBus, step_busy, edge_count
    );

    modport slave (
        input  mode, step, ch_enable,
        output ClockBus, step_busy, edge_count
    );
endinterface

// File: rtl/clock_tree_gen.sv
// Multi-channel clock-tree generator: shared prescaler, per-channel high/low phase FSMs,
// halt/run/single-step control and a channel-0 rising-edge counter.
module clock_tree_gen #(
    parameter int NR_OF_CHANNELS = 2,
    parameter int CNT_BITS       = 8,
    parameter int PRESCALE_BITS  = 16,
    parameter logic [PRESCALE_BITS-1:0] PRESCALE_RELOAD = '0,
    parameter logic [NR_OF_CHANNELS*CNT_BITS-1:0] CH_HIGH_TICKS = {NR_OF_CHANNELS{CNT_BITS'(1)}},
    parameter logic [NR_OF_CHANNELS*CNT_BITS-1:0] CH_LOW_TICKS  = {NR_OF_CHANNELS{CNT_BITS'(1)}}
) (
    input  logic            FPGA_GlobalClock,
    input  logic            FPGA_GlobalReset_n,
    clock_tree_gen_if.slave bus
);

    typedef enum logic {
        CH_LOW  = 1'b0,
        CH_HIGH = 1'b1
    } ch_state_e;

    typedef enum logic {
        STEP_IDLE = 1'b0,
        STEP_BUSY = 1'b1
    } step_state_e;

    // A programmed length of zero behaves as a one-tick phase.
    function automatic logic [CNT_BITS-1:0] phase_len(
        input logic [NR_OF_CHANNELS*CNT_BITS-1:0] ticks,
        input int unsigned                        ch
    );
        logic [CNT_BITS-1:0] len;
        len = ticks[ch*CNT_BITS +: CNT_BITS];
        return (len == '0) ? CNT_BITS'(1) : len;
    endfunction

    logic [PRESCALE_BITS-1:0]  presc_q, presc_d;
    logic                      tick;
    logic                      mode_run, mode_step;
    logic                      step_busy;
    logic                      advance;
    logic [NR_OF_CHANNELS-1:0] ch_adv;
    logic [NR_OF_CHANNELS-1:0] pos_tick, neg_tick;

    ch_state_e                 state_q [NR_OF_CHANNELS];
    ch_state_e                 state_d [NR_OF_CHANNELS];
    logic [CNT_BITS-1:0]       cnt_q   [NR_OF_CHANNELS];
    logic [CNT_BITS-1:0]       cnt_d   [NR_OF_CHANNELS];

    logic [2:0]                step_sync_q;
    logic                      step_rise;
    step_state_e               step_q, step_d;

    logic [31:0]               edge_q, edge_d;

    // Prescaler
    always_comb begin
        tick    = (presc_q == '0);
        presc_d = tick ? PRESCALE_RELOAD : presc_q - PRESCALE_BITS'(1);
    end

    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            presc_q <= PRESCALE_RELOAD;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Advance gating: step_busy only counts while still in step mode, so leaving
    // mode 10 freezes the channels in the same cycle rather than one cycle later.
    always_comb begin
        mode_run  = (bus.mode == 2'b01);
        mode_step = (bus.mode == 2'b10);
        step_busy = (step_q == STEP_BUSY);
        advance   = tick & FPGA_GlobalReset_n & (mode_run | (mode_step & step_busy));
        ch_adv    = {NR_OF_CHANNELS{advance}} & bus.ch_enable;
    end

    // Channel phase FSMs
    always_comb begin
        pos_tick = '0;
        neg_tick = '0;
        for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (ch_adv[i]) begin
                if (cnt_q[i] > CNT_BITS'(1)) begin
                    cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
                end else if (state_q[i] == CH_LOW) begin
                    state_d[i]  = CH_HIGH;
                    cnt_d[i]    = phase_len(CH_HIGH_TICKS, i);
                    pos_tick[i] = 1'b1;
                end else begin
                    state_d[i]  = CH_LOW;
                    cnt_d[i]    = phase_len(CH_LOW_TICKS, i);
                    neg_tick[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
                state_q[i] <= CH_LOW;
                cnt_q[i]   <= phase_len(CH_LOW_TICKS, i);
            end
        end else begin
            for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Step push-button: 2-FF synchroniser plus one stage for edge detection
    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            step_sync_q <= '0;
        end else begin
            step_sync_q <= {step_sync_q[1:0], bus.step};
        end
    end

    assign step_rise = step_sync_q[1] & ~step_sync_q[2];

    always_comb begin
        step_d = step_q;
        case (step_q)
            STEP_IDLE: if (mode_step && step_rise) step_d = STEP_BUSY;
            STEP_BUSY: if (!mode_step || neg_tick[0]) step_d = STEP_IDLE;
            default:   step_d = STEP_IDLE;
        endcase
    end

    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            step_q <= STEP_IDLE;
        end else begin
            step_q <= step_d;
        end
    end

    // Channel-0 rising-edge counter
    assign edge_d = pos_tick[0] ? edge_q + 32'd1 : edge_q;

    always_ff @(posedge FPGA_GlobalClock or negedge FPGA_GlobalReset_n) begin
        if (!FPGA_GlobalReset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    always_comb begin
        bus.ClockBus = '0;
        for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
            bus.ClockBus[5*i +: 5] = {FPGA_GlobalClock, neg_tick[i], pos_tick[i],
                                      state_q[i] != CH_HIGH, state_q[i] == CH_HIGH};
        end
    end

    assign bus.step_busy  = step_busy;
    assign bus.edge_count = edge_q;

endmodule
